// File: rtl/score_bcd_display.sv
// Binary score to multiplexed common-anode seven-segment driver.
// Iterative double-dabble conversion with request buffering, saturation and leading-zero blanking.
module score_bcd_display #(
  parameter int w_value       = 16,
  parameter int n_digits      = 4,
  parameter int w_digit       = 8,
  parameter int w_refresh_div = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [w_value-1:0]   value,
  input  logic                 value_valid,
  output logic                 busy,
  output logic [15:0]          bcd,
  output logic [7:0]           abcdefgh,
  output logic [w_digit-1:0]   digit
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] COMMIT  = 2'd2;

  localparam int sel_w = $clog2(n_digits);
  localparam logic [w_value-1:0] max_score = w_value'(9999);

  logic [1:0]               state;
  logic [w_value-1:0]       shreg;
  logic [15:0]              scratch;
  logic [15:0]              scratch_adj;
  logic [3:0]               step;
  logic [w_value-1:0]       pend_val;
  logic                     pend_flag;
  logic [w_value-1:0]       value_sat;
  logic [w_refresh_div-1:0] refresh_cnt;
  logic [sel_w-1:0]         digit_sel;
  logic [sel_w+1:0]         shamt;
  logic [15:0]              bcd_shift;
  logic [7:0]               seg_pat;
  logic                     blank;

  assign busy      = (state != IDLE);
  assign value_sat = (value > max_score) ? max_score : value;

  always_comb begin
    scratch_adj = scratch;
    for (int unsigned i = 0; i < 4; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5)
        scratch_adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      scratch   <= '0;
      step      <= '0;
      bcd       <= '0;
      pend_val  <= '0;
      pend_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (value_valid || pend_flag) begin
            shreg     <= value_valid ? value_sat : pend_val;
            scratch   <= '0;
            step      <= '0;
            pend_flag <= 1'b0;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          {scratch, shreg} <= {scratch_adj, shreg} << 1;
          step             <= step + 4'd1;
          if (step == 4'd15)
            state <= COMMIT;
        end
        COMMIT: begin
          bcd   <= scratch;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Requests arriving while busy (COMMIT included) replace any older pending one.
      if (state != IDLE && value_valid) begin
        pend_val  <= value_sat;
        pend_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      digit_sel   <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
      if (refresh_cnt == '1)
        digit_sel <= (digit_sel == sel_w'(n_digits - 1)) ? '0 : digit_sel + 1'b1;
    end
  end

  // Shifting the selected nibble down to the bottom also tells us whether all higher digits are zero.
  assign shamt     = {digit_sel, 2'b00};
  assign bcd_shift = bcd >> shamt;
  assign blank     = (digit_sel != '0) && (bcd_shift == '0);

  always_comb begin
    case (bcd_shift[3:0])
      4'd0:    seg_pat = 8'hFC;
      4'd1:    seg_pat = 8'h60;
      4'd2:    seg_pat = 8'hDA;
      4'd3:    seg_pat = 8'hF2;
      4'd4:    seg_pat = 8'h66;
      4'd5:    seg_pat = 8'hB6;
      4'd6:    seg_pat = 8'hBE;
      4'd7:    seg_pat = 8'hE0;
      4'd8:    seg_pat = 8'hFE;
      4'd9:    seg_pat = 8'hF6;
      default: seg_pat = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abcdefgh <= 8'hFF;
      digit    <= '0;
    end else begin
      digit    <= w_digit'(1) << digit_sel;
      abcdefgh <= blank ? 8'hFF : ~seg_pat;
    end
  end

endmodule

// File: tb/tb_score_bcd_display.sv
// Self-checking bench for score_bcd_display: vector table, random values against
// a decimal-arithmetic model, and hand-timed sequences for busy requests and reset.
module tb_score_bcd_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        value_valid;
  logic        busy;
  logic [15:0] bcd;
  logic [7:0]  abcdefgh;
  logic [7:0]  digit;

  int errors = 0;
  int checks = 0;

  localparam logic [7:0] seg_tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                          8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  typedef struct {
    logic [15:0] v;
    logic [15:0] exp_bcd;
  } vec_t;

  score_bcd_display #(
    .w_value(16),
    .n_digits(4),
    .w_digit(8),
    .w_refresh_div(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .value(value),
    .value_valid(value_valid),
    .busy(busy),
    .bcd(bcd),
    .abcdefgh(abcdefgh),
    .digit(digit)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int unsigned sat_val(input int unsigned v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [15:0] model_bcd(input int unsigned v);
    int unsigned s = sat_val(v);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [7:0] model_seg(input int unsigned v, input int k);
    int unsigned s = sat_val(v);
    int unsigned p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (k > 0 && s < p) return 8'hFF;
    return ~seg_tab[(s / p) % 10];
  endfunction

  // One isolated conversion: busy length, committed value and one full scan frame.
  task automatic do_conv(input logic [15:0] v, input logic [15:0] exp_bcd, input string name);
    int n;
    bit seen [4];
    int k;
    @(negedge clk);
    value = v;
    value_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    value_valid = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({name, " busy_len"}, n, 17);
    chk({name, " bcd"}, bcd, exp_bcd);
    @(negedge clk);
    for (int i = 0; i < 4; i++) seen[i] = 1'b0;
    for (int c = 0; c < 16; c++) begin
      k = -1;
      for (int i = 0; i < 4; i++) if (digit == (8'd1 << i)) k = i;
      chk({name, " digit_onehot"}, (k >= 0), 1);
      if (k >= 0) begin
        seen[k] = 1'b1;
        chk({name, " seg"}, abcdefgh, model_seg(v, k));
      end
      @(negedge clk);
    end
    chk({name, " scan_all"}, {seen[3], seen[2], seen[1], seen[0]}, 4'hF);
  endtask

  // Pulses first at E0, second at edge e2, third at edge e3 (0 = none); checks at fixed edges.
  task automatic busy_seq(input logic [15:0] v1, input int e2, input logic [15:0] v2,
                          input int e3, input logic [15:0] v3,
                          input logic [15:0] exp1, input logic [15:0] exp2, input string name);
    @(negedge clk);
    value = v1;
    value_valid = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 38; e++) begin
      @(negedge clk);
      value_valid = 1'b0;
      if (e == e2) begin value = v2; value_valid = 1'b1; end
      if (e == e3) begin value = v3; value_valid = 1'b1; end
      @(posedge clk);
      #1;
      if (e == 17) begin
        chk({name, " bcd_first"}, bcd, exp1);
        chk({name, " busy_gap"}, busy, 1'b0);
      end
      if (e == 18) chk({name, " busy_restart"}, busy, 1'b1);
      if (e == 34) chk({name, " bcd_hold"}, bcd, exp1);
      if (e == 35) chk({name, " bcd_second"}, bcd, exp2);
      if (e == 38) chk({name, " idle_after"}, busy, 1'b0);
    end
  endtask

  initial begin
    vec_t vecs [10];
    int unsigned rv;
    int busy_hits;

    vecs[0] = '{16'd1234,  16'h1234};
    vecs[1] = '{16'd65535, 16'h9999};
    vecs[2] = '{16'd10000, 16'h9999};
    vecs[3] = '{16'd9999,  16'h9999};
    vecs[4] = '{16'd7,     16'h0007};
    vecs[5] = '{16'd0,     16'h0000};
    vecs[6] = '{16'd1000,  16'h1000};
    vecs[7] = '{16'd10,    16'h0010};
    vecs[8] = '{16'd505,   16'h0505};
    vecs[9] = '{16'd9998,  16'h9998};

    rst_n = 1'b0;
    value = '0;
    value_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst abcdefgh", abcdefgh, 8'hFF);
    chk("rst digit", digit, 8'h00);
    chk("rst bcd", bcd, 16'h0000);
    chk("rst busy", busy, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst abcdefgh", abcdefgh, 8'h03);
    chk("post_rst digit", digit, 8'h01);

    foreach (vecs[i]) do_conv(vecs[i].v, vecs[i].exp_bcd, $sformatf("vec%0d", i));

    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0:       rv = $urandom_range(0, 99);
        1:       rv = $urandom_range(9990, 10010);
        default: rv = $urandom_range(0, 65535);
      endcase
      do_conv(16'(rv), model_bcd(rv), $sformatf("rand%0d", i));
    end

    busy_seq(16'd42, 5, 16'd100, 10, 16'd300, 16'h0042, 16'h0300, "busyreq");
    busy_seq(16'd42, 17, 16'd77, 0, 16'd0, 16'h0042, 16'h0077, "commitreq");

    // Reset mid-conversion with a pending request already queued.
    @(negedge clk);
    value = 16'd5555;
    value_valid = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      value_valid = 1'b0;
      if (e == 3) begin value = 16'd1111; value_valid = 1'b1; end
      @(posedge clk);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 1'b0);
    chk("midrst bcd", bcd, 16'h0000);
    chk("midrst abcdefgh", abcdefgh, 8'hFF);
    chk("midrst digit", digit, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    busy_hits = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy) busy_hits++;
    end
    chk("midrst no_pending", busy_hits, 0);
    chk("midrst bcd_after", bcd, 16'h0000);

    do_conv(16'd2024, 16'h2024, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
